data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised big-endian, byte-addressable data memory with a req/ready handshake.
//  Supports byte/half/word accesses, sign/zero extension on loads and programmable wait states.
//  Sits behind the CPU MEM stage; replaces the fixed-word, zero-latency RAM for multi-cycle cores.
// PARAMETERS
//  CAPACITY     256  memory size in bytes; power of two, >= 4
//  WAIT_STATES  1    extra cycles between accept and completion (0..15)
// PORTS
//  clk         in   1   system clock; all state changes on rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  req_i       in   1   access request; sampled only when block is idle or completing
//  we_i        in   1   1 = store, 0 = load
//  size_i      in   2   00 byte, 01 half, 10 word, 11 reserved
//  sign_ext_i  in   1   loads: 1 = sign-extend, 0 = zero-extend (byte/half only)
//  addr_i      in   32  byte address
//  data_i      in   32  store data; byte uses [7:0], half uses [15:0]
//  ready_o     out  1   one-cycle completion pulse
//  data_o      out  32  load result; held until next load completion
//  err_o       out  1   access error flag, valid with ready_o (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, wait counter=0, ready_o=0, data_o=0, err_o=0.
//    Memory array is not cleared. Reset during WAIT aborts the access; no write occurs.
//  - FSM: IDLE -> (req_i) WAIT -> (counter==WAIT_STATES) DONE -> IDLE.
//    If WAIT_STATES=0, IDLE -> (req_i) DONE directly. Latency = WAIT_STATES+1 cycles, accept to ready_o.
//  - On accept, we_i/size_i/sign_ext_i/addr_i/data_i are latched. Inputs are ignored in WAIT.
//  - DONE lasts exactly one cycle, ready_o=1. req_i=1 in DONE is accepted (back-to-back);
//    the next state is WAIT, or DONE again if WAIT_STATES=0.
//  - A store commits on the rising edge entering DONE. A load captures data_o on the same edge.
//  - Big-endian layout: mem[a] is the MSB. Word = {m[a],m[a+1],m[a+2],m[a+3]}; half = {m[a],m[a+1]}.
//  - Byte index = (addr + k) mod CAPACITY per byte, so accesses wrap at the top of memory.
//  - Load extension: byte -> {24{sx&b[7]},b}; half -> {16{sx&h[15]},h}; word unchanged.
//  - Store byte writes only m[a]. Store half writes only m[a],m[a+1]. Other bytes are untouched.
//  - A store completion leaves data_o unchanged.
//  - size_i=11 is treated as word.
//  - Load from a location never written returns X in simulation. The bench must write before reading.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//    - Misaligned accesses set err_o=1 together with ready_o, with normal timing.
//      Misaligned = half with a[0]=1, word with a[1:0]!=0, or size_i=11.
//    - For a misaligned access: store does not write memory; load leaves data_o unchanged.
//    - err_o clears to 0 on the next cycle.
//  DMEM_ALIGN_CHECK_EN undefined:
//    - err_o is tied to 0.
//    - Misaligned accesses execute at the given byte address with per-byte wrap.
// TESTING
//  1 Reset: assert rst_n=0 mid-run -> ready_o=0, data_o=0, err_o=0 immediately, without waiting for a clk edge.
//  2 WAIT_STATES=2: store word 0x11223344 @0x10, then load byte @0x10 -> ready_o 3 cycles after each accept;
//    load returns 0x00000011.
//  3 Store byte 0x80 @0x21, then load byte @0x21 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080.
//    Bytes @0x20,0x22,0x23 are unchanged.
//  4 WAIT_STATES=0, req_i held high for 3 different loads -> ready_o high 3 consecutive cycles, correct data each.
//  5 CAPACITY=256: store word 0xAABBCCDD @0xFE -> m[0xFE]=AA, m[0xFF]=BB, m[0x00]=CC, m[0x01]=DD.
//    Requires DMEM_ALIGN_CHECK_EN undefined.
//  6 DMEM_ALIGN_CHECK_EN defined: store half @0x31 -> err_o=1 with ready_o; m[0x31],m[0x32] unchanged.
//    Reset asserted during WAIT of a store -> target bytes unchanged.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressable data memory with req/ready handshake and programmable wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned CAPACITY    = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  localparam int unsigned AW        = $clog2(CAPACITY);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_sx;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_data;
  logic [7:0]      r_mem [CAPACITY];

  logic            w_accept;
  logic            w_commit;
  logic            w_we;
  logic            w_sx;
  logic [1:0]      w_size;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_data;
  logic [AW-1:0]   w_a0;
  logic [AW-1:0]   w_a1;
  logic [AW-1:0]   w_a2;
  logic [AW-1:0]   w_a3;
  logic [7:0]      w_b0;
  logic [7:0]      w_b1;
  logic [7:0]      w_b2;
  logic [7:0]      w_b3;
  logic [31:0]     w_load;
  logic            w_err;
  logic            w_unused_addr;

  assign w_unused_addr = &{1'b0, addr_i[31:AW]};

  // Reset gates acceptance so a zero-wait build cannot write while rst_n is held low.
  assign w_accept = rst_n && req_i && (r_state != S_WAIT);

  // With no wait states the access completes on the accept edge, so it is served
  // straight from the ports; otherwise from the fields latched at accept.
  always_comb begin
    w_commit = 1'b0;
    w_we     = 1'b0;
    w_sx     = 1'b0;
    w_size   = '0;
    w_addr   = '0;
    w_data   = '0;
    if (ZERO_WAIT) begin
      w_commit = w_accept;
      w_we     = we_i;
      w_sx     = sign_ext_i;
      w_size   = size_i;
      w_addr   = addr_i[AW-1:0];
      w_data   = data_i;
    end else begin
      w_commit = rst_n && (r_state == S_WAIT) && (r_cnt == WS);
      w_we     = r_we;
      w_sx     = r_sx;
      w_size   = r_size;
      w_addr   = r_addr;
      w_data   = r_data;
    end
  end

  assign w_a0 = w_addr;
  assign w_a1 = w_addr + AW'(1);
  assign w_a2 = w_addr + AW'(2);
  assign w_a3 = w_addr + AW'(3);

  assign w_b0 = r_mem[w_a0];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_err = 1'b0;
    case (w_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = w_addr[0];
      2'b10:   w_err = (w_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_load = '0;
    case (w_size)
      2'b00:   w_load = {{24{w_sx & w_b0[7]}}, w_b0};
      2'b01:   w_load = {{16{w_sx & w_b0[7]}}, w_b0, w_b1};
      default: w_load = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      case (w_size)
        2'b00: begin
          r_mem[w_a0] <= w_data[7:0];
        end
        2'b01: begin
          r_mem[w_a0] <= w_data[15:8];
          r_mem[w_a1] <= w_data[7:0];
        end
        default: begin
          r_mem[w_a0] <= w_data[31:24];
          r_mem[w_a1] <= w_data[23:16];
          r_mem[w_a2] <= w_data[15:8];
          r_mem[w_a3] <= w_data[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_sx    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      ready_o <= 1'b0;
      data_o  <= '0;
      err_o   <= 1'b0;
    end else begin
      ready_o <= w_commit;
      err_o   <= w_commit & w_err;
      if (w_commit && !w_we && !w_err) begin
        data_o <= w_load;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (req_i) begin
            r_we   <= we_i;
            r_sx   <= sign_ext_i;
            r_size <= size_i;
            r_addr <= addr_i[AW-1:0];
            r_data <= data_i;
            if (ZERO_WAIT) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'd1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == WS) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: instance 0 has two wait states, instance 1 has none.
module tb_data_mem_ctrl;

  localparam int WS_A = 2;
  localparam int WS_B = 0;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [1:0]  size  [2];
  logic        sx    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rdy   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.CAPACITY(256), .WAIT_STATES(WS_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .sign_ext_i(sx[0]), .addr_i(addr[0]), .data_i(wdata[0]),
    .ready_o(rdy[0]), .data_o(rdata[0]), .err_o(err[0])
  );

  data_mem_ctrl #(.CAPACITY(256), .WAIT_STATES(WS_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .sign_ext_i(sx[1]), .addr_i(addr[1]), .data_i(wdata[1]),
    .ready_o(rdy[1]), .data_o(rdata[1]), .err_o(err[1])
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    if (rdy[d] !== 1'b1) begin
      chk($sformatf("err_idle_dut%0d", d), {31'b0, err[d]}, 32'h0);
      return;
    end
    n = (d == 0) ? qa.size() : qb.size();
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL unexpected_ready_dut%0d: got ready=1 expected no pending access", d);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else        e = qb.pop_front();
    chk({e.nm, "_latency"}, cyc, e.cyc);
    chk({e.nm, "_err"}, {31'b0, err[d]}, {31'b0, e.e});
    chk({e.nm, "_data"}, rdata[d], e.d);
  endtask

  always @(negedge clk) if (rst_n === 1'b1) mon(0);
  always @(negedge clk) if (rst_n === 1'b1) mon(1);

  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; sx[d] = s; addr[d] = a; wdata[d] = wd;
    e.d = ed; e.e = ee; e.nm = nm;
    e.cyc = cyc + 1 + ((d == 0) ? WS_A : WS_B);
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic finish_wait(input int d);
    int n;
    @(negedge clk);
    req[d] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n = (d == 0) ? qa.size() : qb.size();
      if (n == 0) break;
      @(negedge clk);
    end
    n = (d == 0) ? qa.size() : qb.size();
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL timeout_dut%0d: got %0d pending accesses expected 0", d, n);
      if (d == 0) qa.delete();
      else        qb.delete();
    end
  endtask

  task automatic op(input int d, input logic w, input logic [1:0] sz, input logic s,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] ed, input logic ee, input string nm);
    issue(d, w, sz, s, a, wd, ed, ee, nm);
    finish_wait(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; size[d] = '0; sx[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_dut%0d", d), {31'b0, rdy[d]}, 32'h0);
      chk($sformatf("rst_data_dut%0d", d), rdata[d], 32'h0);
      chk($sformatf("rst_err_dut%0d", d), {31'b0, err[d]}, 32'h0);
    end
    rst_n = 1'b1;

    // two wait states: basic word/byte, sign extension, half accesses
    op(0, 1, SZ_W, 0, 32'h10, 32'h11223344, 32'h00000000, 0, "a_st_w10");
    op(0, 0, SZ_B, 0, 32'h10, 32'h0,        32'h00000011, 0, "a_ld_b10");
    op(0, 0, SZ_W, 0, 32'h10, 32'h0,        32'h11223344, 0, "a_ld_w10");
    op(0, 1, SZ_W, 0, 32'h20, 32'h01020304, 32'h11223344, 0, "a_st_w20");
    op(0, 1, SZ_B, 0, 32'h21, 32'hFFFFFF80, 32'h11223344, 0, "a_st_b21");
    op(0, 0, SZ_B, 1, 32'h21, 32'h0,        32'hFFFFFF80, 0, "a_ld_b21_sx");
    op(0, 0, SZ_B, 0, 32'h21, 32'h0,        32'h00000080, 0, "a_ld_b21_zx");
    op(0, 0, SZ_W, 0, 32'h20, 32'h0,        32'h01800304, 0, "a_ld_w20");
    op(0, 0, SZ_H, 1, 32'h22, 32'h0,        32'h00000304, 0, "a_ld_h22_sx");
    op(0, 1, SZ_H, 0, 32'h24, 32'h1234BEEF, 32'h00000304, 0, "a_st_h24");
    op(0, 0, SZ_H, 1, 32'h24, 32'h0,        32'hFFFFBEEF, 0, "a_ld_h24_sx");
    op(0, 0, SZ_H, 0, 32'h24, 32'h0,        32'h0000BEEF, 0, "a_ld_h24_zx");

    // misaligned half store and loads
    op(0, 1, SZ_W, 0, 32'h30, 32'h55667788, 32'h0000BEEF, 0, "a_st_w30");
    op(0, 1, SZ_H, 0, 32'h31, 32'h0000A1B2, 32'h0000BEEF, ALN, "a_st_h31");
    op(0, 0, SZ_W, 0, 32'h30, 32'h0, ALN ? 32'h55667788 : 32'h55A1B288, 0, "a_ld_w30");
    op(0, 0, SZ_H, 0, 32'h31, 32'h0, ALN ? 32'h55667788 : 32'h0000A1B2, ALN, "a_ld_h31");
    op(0, 0, SZ_R, 0, 32'h30, 32'h0, ALN ? 32'h55667788 : 32'h55A1B288, ALN, "a_ld_r30");

    // wrap at the top of memory
    op(0, 1, SZ_B, 0, 32'hFE, 32'h11, ALN ? 32'h55667788 : 32'h55A1B288, 0, "a_st_bFE");
    op(0, 1, SZ_B, 0, 32'hFF, 32'h22, ALN ? 32'h55667788 : 32'h55A1B288, 0, "a_st_bFF");
    op(0, 1, SZ_B, 0, 32'h00, 32'h33, ALN ? 32'h55667788 : 32'h55A1B288, 0, "a_st_b00");
    op(0, 1, SZ_B, 0, 32'h01, 32'h44, ALN ? 32'h55667788 : 32'h55A1B288, 0, "a_st_b01");
    op(0, 1, SZ_W, 0, 32'hFE, 32'hAABBCCDD, ALN ? 32'h55667788 : 32'h55A1B288, ALN, "a_st_wFE");
    op(0, 0, SZ_H, 0, 32'hFE, 32'h0, ALN ? 32'h00001122 : 32'h0000AABB, 0, "a_ld_hFE");
    op(0, 0, SZ_H, 0, 32'h00, 32'h0, ALN ? 32'h00003344 : 32'h0000CCDD, 0, "a_ld_h00");
    op(0, 0, SZ_H, 1, 32'hFF, 32'h0, ALN ? 32'h00003344 : 32'hFFFFBBCC, ALN, "a_ld_hFF");
    op(0, 0, SZ_W, 0, 32'h21, 32'h0, ALN ? 32'h00003344 : 32'h800304BE, ALN, "a_ld_w21");

    // zero wait states with req held: back-to-back completions
    issue(1, 1, SZ_W, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, "b_st_w40");
    issue(1, 1, SZ_W, 0, 32'h44, 32'h0BADC0DE, 32'h0, 0, "b_st_w44");
    issue(1, 1, SZ_B, 0, 32'h48, 32'h0000007F, 32'h0, 0, "b_st_b48");
    finish_wait(1);
    issue(1, 0, SZ_W, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, "b_ld_w40");
    issue(1, 0, SZ_H, 1, 32'h46, 32'h0, 32'hFFFFC0DE, 0, "b_ld_h46");
    issue(1, 0, SZ_B, 1, 32'h48, 32'h0, 32'h0000007F, 0, "b_ld_b48");
    issue(1, 1, SZ_B, 0, 32'h49, 32'h01, 32'h0000007F, 0, "b_st_b49");
    finish_wait(1);

    // async reset while dut0 is mid-store and dut1 is presenting ready
    issue(0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "a_st_aborted");
    issue(1, 0, SZ_W, 0, 32'h44, 32'h0, 32'h0BADC0DE, 0, "b_ld_pre_rst");
    req[0] = 1'b0;
    @(posedge clk);
    #2;
    req[1] = 1'b0;
    chk("b_ready_before_rst", {31'b0, rdy[1]}, 32'h1);
    rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_ready_dut%0d", d), {31'b0, rdy[d]}, 32'h0);
      chk($sformatf("midrst_data_dut%0d", d), rdata[d], 32'h0);
      chk($sformatf("midrst_err_dut%0d", d), {31'b0, err[d]}, 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(0, 0, SZ_W, 0, 32'h10, 32'h0, 32'h11223344, 0, "a_ld_w10_post_rst");
    op(0, 0, SZ_B, 0, 32'h11, 32'h0, 32'h00000022, 0, "a_ld_b11_post_rst");
    op(1, 0, SZ_W, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, "b_ld_w40_post_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
